// File: rtl/mux_cfg_chain_ctrl_if.sv
// Bitstream word handshake between the programming host
// and the configuration-chain controller.
interface mux_cfg_chain_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/mux_cfg_chain_ctrl.sv
// Loads routing-mux select bits into the ccff chain LSB-first,
// then recirculates once and compares read-back CRC-8 against load CRC-8.
module mux_cfg_chain_ctrl #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    input  logic                 start,
    mux_cfg_chain_ctrl_if.slave  cfg,
    output logic                 ccff_head,
    output logic                 ccff_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LEN  = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shifter;
    logic [BW-1:0]     queued;
    logic [CW-1:0]     shifted;
    logic [CW-1:0]     vcnt;
    logic [CW-1:0]     taken;
    logic [7:0]        crc_ld;
    logic [7:0]        crc_rb;
    logic              head_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [CW-1:0]     remain;
    logic [BW-1:0]     take;
    logic              ready;
    logic              accept;
    logic [7:0]        crc_rb_nxt;

    function automatic logic [7:0] crc_step(
        input logic [7:0] c,
        input logic       b
    );
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // queued counts bits still in the shifter behind the one on ccff_head,
    // so a new word may land on the edge that retires the last bit.
    always_comb begin
        remain     = LEN - taken;
        take       = (32'(remain) >= WORD_W) ? BW'(WORD_W) : BW'(remain);
        ready      = (state == LOAD) && (queued == '0) && (remain != '0);
        accept     = ready && cfg.cfg_valid;
        crc_rb_nxt = crc_step(crc_rb, ccff_tail);
    end

    assign cfg.cfg_ready = ready;
    assign ccff_head     = (state == VERIFY) ? ccff_tail : head_q;
    assign ccff_en       = en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state   <= IDLE;
            shifter <= '0;
            queued  <= '0;
            shifted <= '0;
            vcnt    <= '0;
            taken   <= '0;
            crc_ld  <= '0;
            crc_rb  <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        en_q    <= 1'b0;
                        queued  <= '0;
                        shifted <= '0;
                        vcnt    <= '0;
                        taken   <= '0;
                        crc_ld  <= '0;
                        crc_rb  <= '0;
                    end
                end
                LOAD: begin
                    if (en_q) begin
                        crc_ld <= crc_step(crc_ld, head_q);
                        if (shifted != LEN) begin
                            shifted <= shifted + 1'b1;
                        end
                    end
                    if (en_q && shifted == LAST) begin
                        state <= VERIFY;
                        en_q  <= 1'b1;
                    end else if (accept) begin
                        head_q  <= cfg.cfg_data[0];
                        shifter <= cfg.cfg_data >> 1;
                        queued  <= take - 1'b1;
                        taken   <= taken + CW'(take);
                        en_q    <= 1'b1;
                    end else if (queued != '0) begin
                        head_q  <= shifter[0];
                        shifter <= shifter >> 1;
                        queued  <= queued - 1'b1;
                        en_q    <= 1'b1;
                    end else begin
                        en_q <= 1'b0;
                    end
                end
                VERIFY: begin
                    crc_rb <= crc_rb_nxt;
                    if (vcnt != LEN) begin
                        vcnt <= vcnt + 1'b1;
                    end
                    if (vcnt == LAST) begin
                        state  <= DONE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= (crc_rb_nxt != crc_ld);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_cfg_chain_ctrl.sv
// Bench for mux_cfg_chain_ctrl: 40- and 10-flop chains with a
// behavioural chain model, fault injection, table and random loads.
module tb_mux_cfg_chain_ctrl;

    typedef bit bq_t[$];

    typedef struct {
        bit               s;
        logic [5:0][7:0]  w;
        logic [5:0][3:0]  g;
        bit               f;
        int               smid;
        int               ed;
        bit               ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic h_start = 1'b0;
    logic h_valid = 1'b0;
    logic [7:0] h_data = 8'h00;
    bit   sel = 1'b0;
    bit   fault = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_cfg_chain_ctrl_if #(.WORD_W(8)) if40 ();
    mux_cfg_chain_ctrl_if #(.WORD_W(8)) if10 ();

    logic st40, st10;
    logic head40, en40, busy40, done40, err40, tail40;
    logic head10, en10, busy10, done10, err10, tail10;
    logic [39:0] ch40 = '0;
    logic [9:0]  ch10 = '0;
    logic [39:0] n40;

    assign st40 = h_start & ~sel;
    assign st10 = h_start & sel;
    assign if40.cfg_valid = h_valid & ~sel;
    assign if10.cfg_valid = h_valid & sel;
    assign if40.cfg_data  = h_data;
    assign if10.cfg_data  = h_data;

    mux_cfg_chain_ctrl #(.CHAIN_LEN(40), .WORD_W(8)) dut40 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(st40), .cfg(if40),
        .ccff_head(head40), .ccff_en(en40), .ccff_tail(tail40),
        .busy(busy40), .done(done40), .err(err40)
    );

    mux_cfg_chain_ctrl #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(st10), .cfg(if10),
        .ccff_head(head10), .ccff_en(en10), .ccff_tail(tail10),
        .busy(busy10), .done(done10), .err(err10)
    );

    // Chain model; flop 17 of the long chain can be stuck at 1.
    assign tail40 = ch40[39];
    assign tail10 = ch10[9];
    always_comb begin
        n40 = {ch40[38:0], head40};
        if (fault) n40[17] = 1'b1;
    end
    always @(posedge clk) begin
        if (en40) ch40 <= n40;
        if (en10) ch10 <= {ch10[8:0], head10};
    end

    logic o_en, o_head, o_busy, o_done, o_err, o_rdy;
    assign o_en   = sel ? en10 : en40;
    assign o_head = sel ? head10 : head40;
    assign o_busy = sel ? busy10 : busy40;
    assign o_done = sel ? done10 : done40;
    assign o_err  = sel ? err10 : err40;
    assign o_rdy  = sel ? if10.cfg_ready : if40.cfg_ready;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input bq_t s);
        logic [7:0] c;
        bit fb;
        c = 8'h00;
        foreach (s[i]) begin
            fb = c[7] ^ s[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Load L bits then recirculate L times; returns bits seen at the tail.
    function automatic bq_t model_rb(input bq_t s, input int L, input bit f);
        bit c[40];
        bq_t o;
        bit b;
        foreach (c[j]) c[j] = 1'b0;
        for (int i = 0; i < 2 * L; i++) begin
            b = (i < L) ? s[i] : c[L-1];
            if (i >= L) o.push_back(b);
            for (int j = L - 1; j > 0; j--) c[j] = c[j-1];
            c[0] = b;
            if (f) c[17] = 1'b1;
        end
        return o;
    endfunction

    task automatic run_case(input string nm, input bit s,
                            input logic [5:0][7:0] w,
                            input logic [5:0][3:0] g,
                            input bit f, input int smid,
                            output int done_at, output logic err_at);
        int L, rel, wi, acc, en_cnt, first_en, used, gsum;
        int gl[6];
        bq_t heads, strm, rb;
        logic [39:0] hv, sv, ev, av;
        L = s ? 10 : 40;
        wi = 0; acc = 0; en_cnt = 0; first_en = -1; gsum = 0;
        done_at = -1; err_at = 1'bx;
        for (int k = 0; k < 6; k++) gl[k] = int'(g[k]);
        for (int k = 0; k < 6; k++)
            for (int b = 0; b < 8; b++)
                if (strm.size() < L) strm.push_back(w[k][b]);
        used = (L + 7) / 8;
        for (int k = 0; k < used; k++) gsum += gl[k];
        rb = model_rb(strm, L, f);
        sel = s;
        fault = f;
        @(negedge clk);
        base = cyc;
        for (rel = 0; rel <= 400; rel++) begin
            if (rel > 0) @(negedge clk);
            h_start = (rel == 0) || (rel == smid);
            if (rel == 1) begin
                chk({nm, ".entry"}, {61'd0, o_busy, o_err, o_rdy}, 64'h5);
            end
            if (rel > 0) begin
                if (o_en) begin
                    en_cnt++;
                    if (first_en < 0) first_en = rel;
                    if (o_busy && heads.size() < L) heads.push_back(o_head);
                end
                if (o_done) begin
                    done_at = rel;
                    err_at = o_err;
                    break;
                end
            end
            if (o_rdy && wi < 6 && gl[wi] > 0) begin
                h_valid = 1'b0;
                gl[wi]--;
            end else if (wi < 6) begin
                h_valid = 1'b1;
                h_data = w[wi];
                if (o_rdy) begin
                    wi++;
                    acc++;
                end
            end else begin
                h_valid = 1'b0;
            end
        end
        h_valid = 1'b0;
        h_start = 1'b0;
        if (done_at < 0) begin
            chk({nm, ".timeout"}, 64'd1, 64'd0);
            return;
        end
        hv = '0; sv = '0; ev = '0;
        foreach (heads[i]) hv[i] = heads[i];
        for (int i = 0; i < L; i++) begin
            sv[i] = strm[i];
            ev[L-1-i] = strm[i];
        end
        av = s ? {30'd0, ch10} : ch40;
        chk({nm, ".done_cyc"}, 64'(done_at), 64'(2 * L + 2 + gsum));
        chk({nm, ".en_cnt"}, 64'(en_cnt), 64'(2 * L));
        chk({nm, ".first_en"}, 64'(first_en), 64'(2 + gl[0] + int'(g[0]) - gl[0]));
        chk({nm, ".accepted"}, 64'(acc), 64'(used));
        chk({nm, ".heads"}, {24'd0, hv}, {24'd0, sv});
        chk({nm, ".err"}, {63'd0, err_at}, {63'd0, crc_of(strm) != crc_of(rb)});
        if (!f) chk({nm, ".chain"}, {24'd0, av}, {24'd0, ev});
    endtask

    function automatic vec_t mk(bit s, logic [47:0] w, logic [23:0] g,
                                bit f, int smid, int ed, bit ee);
        vec_t v;
        v.s = s; v.w = w; v.g = g; v.f = f;
        v.smid = smid; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        int d;
        logic e;
        logic [5:0][7:0] rw;
        logic [5:0][3:0] rg;
        int rs, rsm;

        tbl[0] = mk(0, 48'h11_96_00_FF_3C_A5, 24'h0, 0, 0, 82, 0);
        tbl[1] = mk(1, 48'h00_00_00_33_FF_5A, 24'h0, 0, 0, 22, 0);
        tbl[2] = mk(0, 48'h11_96_00_FF_3C_A5, 24'h000300, 0, 0, 85, 0);
        tbl[3] = mk(0, 48'h0, 24'h0, 1, 0, 82, 1);
        tbl[4] = mk(0, 48'h00_9A_78_56_34_12, 24'h0, 0, 30, 82, 0);
        tbl[5] = mk(1, 48'h00_00_00_77_80_01, 24'h000020, 0, 7, 24, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst40", {58'd0, en40, head40, busy40, done40, err40, if40.cfg_ready}, 64'd0);
        chk("rst10", {58'd0, en10, head10, busy10, done10, err10, if10.cfg_ready}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_case($sformatf("tbl%0d", i), tbl[i].s, tbl[i].w, tbl[i].g,
                     tbl[i].f, tbl[i].smid, d, e);
            chk($sformatf("tbl%0d.done_exp", i), 64'(d), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d.err_exp", i), {63'd0, e}, {63'd0, tbl[i].ee});
        end

        // Reset asserted during cycle 20 of a load aborts it.
        sel = 1'b0;
        fault = 1'b0;
        @(negedge clk);
        h_start = 1'b1;
        h_valid = 1'b1;
        h_data = 8'hFF;
        for (int rel = 1; rel <= 21; rel++) begin
            @(negedge clk);
            h_start = 1'b0;
            if (rel == 19) chk("midrst.active", {62'd0, en40, busy40}, 64'h3);
            if (rel == 20) rst_n = 1'b0;
            if (rel == 21)
                chk("midrst.outs",
                    {58'd0, en40, head40, busy40, done40, err40, if40.cfg_ready}, 64'd0);
        end
        h_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.idle", {62'd0, busy40, if40.cfg_ready}, 64'd0);

        for (int r = 0; r < 16; r++) begin
            rs = int'($urandom_range(0, 1));
            for (int k = 0; k < 6; k++) begin
                rw[k] = 8'($urandom);
                rg[k] = 4'($urandom_range(0, 3));
            end
            rsm = ($urandom_range(0, 1) == 1)
                ? int'($urandom_range(2, rs ? 20 : 80)) : 0;
            run_case($sformatf("rnd%0d", r), rs[0], rw, rg, 1'b0, rsm, d, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
